cond_ctrl_pipe: RTL
===================

// Module: cond_ctrl_pipe
// PURPOSE
//  Parametrised control-word pipeline for the ARM pipeline: carries decoded control bits from D through NSTAGE stages (E,M,W,...).
//  Adds per-stage stall/flush, condition-code gating at E, a grouped-write flags register with sticky Q, and early-branch evaluation.
//  Sits between the decoder and the datapath/hazard unit; supersedes fixed-width hand-built E/M/W control registers.
// PARAMETERS
//  CW      8  control-word width; bit0 RegWrite, bit1 MemWrite, bit2 PCSrc, bit3 NoWrite, bits CW-1:4 passthrough
//  NSTAGE  3  stages after D; index 0 = E, 1 = M, 2 = W (minimum 2)
// PORTS
//  clk          in   1          clock, rising edge
//  reset        in   1          synchronous, active-low reset
//  CtrlD        in   CW         decoded control word of instruction in D
//  ValidD       in   1          D holds a real instruction
//  CondD        in   4          InstrD[31:28]
//  FlagWriteD   in   3          [2] N,Z  [1] C,V  [0] Q (sticky)
//  BranchD      in   1          D is a branch
//  ALUFlagsE    in   5          {N,Z,C,V,Q} from ALU in E
//  StallS       in   NSTAGE     stage k holds its contents
//  FlushS       in   NSTAGE     stage k loads a bubble
//  CtrlS        out  NSTAGE*CW  control word of stage k at [k*CW +: CW]; stage>=1 words are gated
//  ValidS       out  NSTAGE     stage k holds a real instruction
//  CondExE      out  1          condition passes for E instruction (0 if E invalid)
//  FlagsE       out  5          architectural flags {N,Z,C,V,Q}
//  FlagsNextE   out  5          flags after E commits (bypass for early eval)
//  BranchTakenD out  1          BranchD & ValidD & cond(CondD, FlagsNextE)
//  PCWrPendingF out  1          PCSrc pending in D or any valid stage
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): all stage words, ValidS, CondE, FlagWriteE, FlagsE <= 0; all outputs evaluate to 0.
//  - Stage k register update priority: reset > FlushS[k] (bubble: word 0, valid 0) > StallS[k] (hold)
//    > k>0 and StallS[k-1] (bubble) > load from stage k-1 (k=0 loads CtrlD/ValidD/CondD/FlagWriteD).
//  - Flush overrides stall in the same cycle; flushing a stalled stage yields a bubble next cycle.
//  - Condition codes: all 16 ARM codes EQ..AL; 4'b1111 treated as never-execute.
//  - CondExE = ValidS[0] & cond(CondE, FlagsE). Latency D->E register 1 cycle; CtrlS[0] is ungated.
//  - E->M transfer gates: RegWrite &= CondExE & ~NoWrite; MemWrite &= CondExE; PCSrc &= CondExE; other bits unchanged.
//  - FlagsNextE: if CondExE & FlagWriteE[2] take N,Z from ALU; [1] C,V; [0] Q = FlagsE.Q | ALUFlagsE.Q; else hold.
//  - FlagsE <= FlagsNextE each edge unless StallS[0]; flushing E at same edge still commits (E instr already executed).
//  - Q only clears on reset (sticky); never cleared by FlagWrite.
//  - BranchTakenD is combinational from FlagsNextE; a flags-writing E instr feeds a conditional branch in D with zero bubbles.
//  - PCWrPendingF = (CtrlD[2]&ValidD) | OR over k of (CtrlS[k][2]&ValidS[k]).
//  - Bubbles never write flags and never assert gated RegWrite/MemWrite/PCSrc.
// STRUCTURE
//  - Shared package ctrl_pkg: condition-code constants (EQ..AL,NV), flag indices N=4,Z=3,C=2,V=1,Q=0,
//    control-bit indices CB_REGW/CB_MEMW/CB_PCSRC/CB_NOWR.
//  - Sub-module cond_eval (combinational: cond[3:0], flags[4:0] -> pass), instantiated for E and early-D.
//  - Stage registers via generate loop over NSTAGE.
// TESTING
//  1 Reset: hold reset=0 3 cycles with CtrlD=8'hFF,ValidD=1 -> all CtrlS=0, ValidS=0, FlagsE=0, PCWrPendingF=0.
//  2 Gating: FlagsE.Z=0, CondD=EQ, CtrlD=8'h03 -> word at M is 8'h00; CondD=AL -> M word 8'h03, W 8'h03 one cycle later.
//  3 Early branch: E=ADDS with ALUFlagsE Z=1, FlagWrite=3'b100; D=BEQ -> BranchTakenD=1 same cycle; FlagsE.Z=1 next.
//  4 Sticky Q: E FlagWrite=3'b001 ALUFlagsE.Q=1, then FlagWrite=3'b001 Q=0 -> FlagsE.Q stays 1 until reset.
//  5 Stall/flush: StallS=3'b001 two cycles -> E holds, M gets bubbles; StallS[0]=1 & FlushS[0]=1 -> E bubble next cycle.
//  6 PC pending: CtrlD=8'h04 valid -> PCWrPendingF=1 for 4 cycles (D,E,M,W) then 0; with CondE failing -> drops after E.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-word pipeline: ARM condition codes,
// flag bit positions and control-word bit positions.
package ctrl_pkg;

  typedef enum logic [3:0] {
    EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
    MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
    HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
    GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
  } cond_e;

  // Flag positions within {N,Z,C,V,Q}
  localparam int N = 4;
  localparam int Z = 3;
  localparam int C = 2;
  localparam int V = 1;
  localparam int Q = 0;

  localparam int CB_REGW  = 0;
  localparam int CB_MEMW  = 1;
  localparam int CB_PCSRC = 2;
  localparam int CB_NOWR  = 3;

endpackage

// File: rtl/cond_eval.sv
// ARM condition-code evaluator; NV (4'b1111) never passes.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       pass
);

  logic flagN, flagZ, flagC, flagV;
  logic unusedQ;

  assign flagN   = flags[N];
  assign flagZ   = flags[Z];
  assign flagC   = flags[C];
  assign flagV   = flags[V];
  // Q is sticky saturation state and never participates in a condition
  assign unusedQ = flags[Q];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      EQ:      pass = flagZ;
      NE:      pass = ~flagZ;
      CS:      pass = flagC;
      CC:      pass = ~flagC;
      MI:      pass = flagN;
      PL:      pass = ~flagN;
      VS:      pass = flagV;
      VC:      pass = ~flagV;
      HI:      pass = flagC & ~flagZ;
      LS:      pass = ~flagC | flagZ;
      GE:      pass = (flagN == flagV);
      LT:      pass = (flagN != flagV);
      GT:      pass = ~flagZ & (flagN == flagV);
      LE:      pass = flagZ | (flagN != flagV);
      AL:      pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_ctrl_pipe.sv
// Control-word pipeline D->E->M->W.. with cond gating at E, sticky-Q flags, early branch.
// Latency: 1 cycle per stage; flags/branch bypass is combinational.
// Backpressure: per-stage StallS holds, upstream stall inserts bubbles, FlushS overrides stall.
module cond_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int CW     = 8,
  parameter int NSTAGE = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CW-1:0]        CtrlD,
  input  logic                 ValidD,
  input  logic [3:0]           CondD,
  input  logic [2:0]           FlagWriteD,
  input  logic                 BranchD,
  input  logic [4:0]           ALUFlagsE,
  input  logic [NSTAGE-1:0]    StallS,
  input  logic [NSTAGE-1:0]    FlushS,
  output logic [NSTAGE*CW-1:0] CtrlS,
  output logic [NSTAGE-1:0]    ValidS,
  output logic                 CondExE,
  output logic [4:0]           FlagsE,
  output logic [4:0]           FlagsNextE,
  output logic                 BranchTakenD,
  output logic                 PCWrPendingF
);

  logic [NSTAGE-1:0][CW-1:0] stageWord;
  logic [NSTAGE-1:0]         stageVld;
  logic [3:0]                condE;
  logic [2:0]                flagWriteE;
  logic [4:0]                flagsQ;
  logic [CW-1:0]             gatedE;
  logic                      condPassE;
  logic                      condPassD;
  logic                      pcPending;

  cond_eval uCondE (.cond(condE), .flags(flagsQ),     .pass(condPassE));
  cond_eval uCondD (.cond(CondD), .flags(FlagsNextE), .pass(condPassD));

  assign CondExE = stageVld[0] & condPassE;

  always_comb begin
    gatedE           = stageWord[0];
    gatedE[CB_REGW]  = stageWord[0][CB_REGW] & CondExE & ~stageWord[0][CB_NOWR];
    gatedE[CB_MEMW]  = stageWord[0][CB_MEMW] & CondExE;
    gatedE[CB_PCSRC] = stageWord[0][CB_PCSRC] & CondExE;
  end

  for (genvar k = 0; k < NSTAGE; k++) begin : gStage
    logic [CW-1:0] wordQ;
    logic          vldQ;
    logic [CW-1:0] srcWord;
    logic          srcVld;
    logic          upBubble;

    if (k == 0) begin : gSrcD
      assign srcWord  = CtrlD;
      assign srcVld   = ValidD;
      assign upBubble = 1'b0;
    end else if (k == 1) begin : gSrcE
      assign srcWord  = gatedE;
      assign srcVld   = stageVld[0];
      assign upBubble = StallS[0];
    end else begin : gSrcPrev
      assign srcWord  = stageWord[k-1];
      assign srcVld   = stageVld[k-1];
      assign upBubble = StallS[k-1];
    end

    always_ff @(posedge clk) begin
      if (!reset || FlushS[k]) begin
        wordQ <= '0;
        vldQ  <= 1'b0;
      end else if (!StallS[k]) begin
        wordQ <= upBubble ? '0 : srcWord;
        vldQ  <= upBubble ? 1'b0 : srcVld;
      end
    end

    assign stageWord[k] = wordQ;
    assign stageVld[k]  = vldQ;
  end

  // E-only side state travels with stage 0 under the same priority
  always_ff @(posedge clk) begin
    if (!reset || FlushS[0]) begin
      condE      <= 4'h0;
      flagWriteE <= 3'b000;
    end else if (!StallS[0]) begin
      condE      <= CondD;
      flagWriteE <= FlagWriteD;
    end
  end

  always_comb begin
    FlagsNextE = flagsQ;
    if (CondExE) begin
      if (flagWriteE[2]) begin
        FlagsNextE[N] = ALUFlagsE[N];
        FlagsNextE[Z] = ALUFlagsE[Z];
      end
      if (flagWriteE[1]) begin
        FlagsNextE[C] = ALUFlagsE[C];
        FlagsNextE[V] = ALUFlagsE[V];
      end
      if (flagWriteE[0]) begin
        FlagsNextE[Q] = flagsQ[Q] | ALUFlagsE[Q];
      end
    end
  end

  // A flushed E instruction has already executed, so its flags still commit
  always_ff @(posedge clk) begin
    if (!reset) begin
      flagsQ <= 5'b0;
    end else if (!StallS[0]) begin
      flagsQ <= FlagsNextE;
    end
  end

  always_comb begin
    pcPending = CtrlD[CB_PCSRC] & ValidD;
    for (int k = 0; k < NSTAGE; k++) begin
      pcPending = pcPending | (stageWord[k][CB_PCSRC] & stageVld[k]);
    end
  end

  assign PCWrPendingF = reset & pcPending;
  assign BranchTakenD = reset & BranchD & ValidD & condPassD;
  assign CtrlS        = stageWord;
  assign ValidS       = stageVld;
  assign FlagsE       = flagsQ;

endmodule
